digit_serial_subtractor: RTL and testbench
==========================================

// Module: digit_serial_subtractor
// PURPOSE
//   Parametrised, multi-cycle successor to the 4-bit ripple-borrow subtractor.
//   Computes Diff = A - B - Bin over WIDTH bits, DIGIT bits per clock.
//   The borrow is carried between cycles in a register.
//   Valid/ready handshakes on both sides let it sit in streaming datapaths
//   where area matters more than latency. Provides borrow-out and zero flags.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be >= 1
//   DIGIT  4   bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0
//   (derived) NDIG = WIDTH/DIGIT digit cycles per operation
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand set A/B/Bin is valid
//   in_ready   out  1      block can accept an operand set
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   Bin        in   1      borrow-in (LSB)
//   out_valid  out  1      Diff/Bout/Zero hold a completed result
//   out_ready  in   1      consumer accepts the result
//   Diff       out  WIDTH  (A - B - Bin) mod 2^WIDTH
//   Bout       out  1      borrow-out: 1 iff A < B + Bin (unsigned)
//   Zero       out  1      1 iff Diff == 0
// BEHAVIOUR
//   FSM states: IDLE, RUN, DONE.
//   - Reset value of the state register is IDLE.
//   Reset (async, any time, including mid-RUN):
//   - state=IDLE; digit counter=0; borrow register=0.
//   - Diff=0, Bout=0, Zero=0, out_valid=0, in_ready=1.
//   - Any in-flight operation is discarded; no result is produced for it.
//   IDLE:
//   - in_ready=1, out_valid=0.
//   - Transfer occurs when in_valid & in_ready at a rising edge.
//   - On transfer: capture A, B and Bin; borrow register=Bin; counter=0; go to RUN.
//   - Input changes after capture are ignored.
//   RUN:
//   - in_ready=0, out_valid=0.
//   - Each cycle processes digit k=counter, bits [k*DIGIT +: DIGIT].
//   - Per bit, full-subtract: d=a^b^br; br'=(~a&b)|((~a|b)&br), rippling within the digit.
//   - Write the digit into Diff; borrow register gets the digit's borrow-out; counter++.
//   - After digit NDIG-1: Bout = final borrow; Zero = (Diff==0) incl. last digit; go to DONE.
//   Latency:
//   - out_valid rises exactly NDIG clock edges after the accepting edge.
//   - WIDTH=16, DIGIT=4: 4 cycles. DIGIT=WIDTH: 1 cycle.
//   DONE:
//   - out_valid=1; Diff/Bout/Zero held stable while out_valid & ~out_ready.
//   - On out_valid & out_ready at a rising edge: go to IDLE.
//   - in_ready=0 throughout DONE, so no overlap of operations.
//   - Next accept is possible the cycle after result handoff.
//   - Throughput is one operation per NDIG+2 cycles.
//   Interface rules:
//   - in_ready and out_valid are driven from registered state only (no comb paths from inputs).
//   - Diff is undefined-but-stable during RUN; consumers qualify with out_valid.
//   - Wrap-around: the result is modulo 2^WIDTH; underflow is reported only via Bout.
//   - Simultaneous in_valid during DONE is not accepted until IDLE.
// TESTING
//   - W=16,D=4: A=16'h1234, B=16'h0235, Bin=0 -> Diff=16'h0FFF, Bout=0, Zero=0; out_valid 4 edges after accept.
//   - A=16'h0000, B=16'h0001, Bin=0 -> Diff=16'hFFFF, Bout=1, Zero=0 (borrow ripples through all digits).
//   - A=B=16'hABCD: Bin=0 -> Diff=0, Zero=1, Bout=0; Bin=1 -> Diff=16'hFFFF, Bout=1, Zero=0.
//   - Backpressure: hold out_ready=0 for 5 cycles.
//     -> outputs stable, in_ready=0, new in_valid ignored.
//     -> out_ready=1 then next op is accepted.
//   - Reset mid-op: assert rst in the 2nd RUN cycle.
//     -> all outputs 0, in_ready=1 immediately, no stale out_valid afterwards.
//   - W=4,D=1 and W=4,D=4: exhaustive A,B,Bin (512 cases) vs model {Bout,Diff}=A-B-Bin.
//     -> latency 4 and 1 respectively.

Source files
------------

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle subtractor: Diff = A - B - Bin, DIGIT bits per clock with the
// borrow carried between cycles in a register; valid/ready on both sides.
module digit_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, zero_q, zero_d;

    logic [DIGIT-1:0] dig;
    logic             br, ab, bb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        dig     = '0;
        br      = br_q;
        ab      = 1'b0;
        bb      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Borrow ripples bit by bit inside the current digit.
                for (int i = 0; i < DIGIT; i++) begin
                    ab     = a_q[int'(cnt_q)*DIGIT + i];
                    bb     = b_q[int'(cnt_q)*DIGIT + i];
                    dig[i] = ab ^ bb ^ br;
                    br     = (~ab & bb) | ((~ab | bb) & br);
                end
                diff_d[int'(cnt_q)*DIGIT +: DIGIT] = dig;
                br_d  = br;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    bout_d  = br;
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Zero      = zero_q;
endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor: three configurations checked every cycle
// against an arithmetic model of result value and handshake timing.
module tb_digit_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam int WID [3] = '{16, 4, 4};
    localparam int NDG [3] = '{4, 4, 1};

    logic        iv [3];
    logic        ordy [3];
    logic        bin [3];
    logic [15:0] a [3];
    logic [15:0] b [3];
    logic        ir [3];
    logic        ov [3];
    logic        bo [3];
    logic        zr [3];
    logic [15:0] dif [3];
    logic [3:0]  d41, d44;

    int checks = 0;
    int failures = 0;

    digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .A(a[0]), .B(b[0]), .Bin(bin[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .Diff(dif[0]), .Bout(bo[0]), .Zero(zr[0]));

    digit_serial_subtractor #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .A(a[1][3:0]), .B(b[1][3:0]), .Bin(bin[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .Diff(d41), .Bout(bo[1]), .Zero(zr[1]));

    digit_serial_subtractor #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .A(a[2][3:0]), .B(b[2][3:0]), .Bin(bin[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .Diff(d44), .Bout(bo[2]), .Zero(zr[2]));

    assign dif[1] = {12'h000, d41};
    assign dif[2] = {12'h000, d44};

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Behavioural model: one operation in flight per instance; result appears
    // NDIG edges after acceptance and stays until handed off.
    bit          pend [3];
    longint      rdy [3];
    longint      ecnt = 0;
    logic [15:0] ediff [3];
    bit          ebo [3];
    bit          ezr [3];
    int          ndone [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0; rdy[i] = 0; ndone[i] = 0;
            ediff[i] = '0; ebo[i] = 0; ezr[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 3; i++) pend[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    int msk, r;
                    bit vld;
                    msk = (1 << WID[i]) - 1;
                    vld = pend[i] && (ecnt >= rdy[i]);
                    if (vld && ordy[i]) begin
                        pend[i] = 0;
                        ndone[i]++;
                    end else if (!pend[i] && iv[i]) begin
                        r = int'(a[i]) & msk;
                        r = r - (int'(b[i]) & msk) - int'(bin[i]);
                        pend[i]  = 1;
                        rdy[i]   = ecnt + 1 + NDG[i];
                        ediff[i] = 16'(r & msk);
                        ebo[i]   = (r < 0);
                        ezr[i]   = ((r & msk) == 0);
                    end
                end
                ecnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                bit evld;
                evld = pend[i] && (ecnt >= rdy[i]);
                chk("out_valid", i, 32'(ov[i]), 32'(evld));
                chk("in_ready", i, 32'(ir[i]), 32'(!pend[i]));
                if (rst) begin
                    chk("rst_diff", i, 32'(dif[i]), 32'h0);
                    chk("rst_flags", i, {30'h0, bo[i], zr[i]}, 32'h0);
                end else if (evld) begin
                    chk("diff", i, 32'(dif[i]), 32'(ediff[i]));
                    chk("bout", i, 32'(bo[i]), 32'(ebo[i]));
                    chk("zero", i, 32'(zr[i]), 32'(ezr[i]));
                end
            end
        end
    end

    task automatic wait_ready(input int i);
        int t = 0;
        @(negedge clk);
        while (!ir[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ir[i]) chk("ready_timeout", i, 32'(ir[i]), 32'h1);
    endtask

    // Directed op on the 16/4 instance with hand-computed expectations.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic bn,
                        input logic [15:0] edf, input logic eb, input logic ez, input int hold);
        int lat = 0;
        wait_ready(0);
        a[0] = av; b[0] = bv; bin[0] = bn; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        a[0] = 16'($urandom); b[0] = 16'($urandom); bin[0] = 1'($urandom);
        while (!ov[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency16", 0, 32'(lat), 32'd4);
        chk("lit_diff", 0, 32'(dif[0]), 32'(edf));
        chk("lit_bout", 0, 32'(bo[0]), 32'(eb));
        chk("lit_zero", 0, 32'(zr[0]), 32'(ez));
        repeat (hold) begin
            iv[0] = 1'b1; a[0] = 16'($urandom); b[0] = 16'($urandom);
            @(negedge clk);
            chk("hold_diff", 0, 32'(dif[0]), 32'(edf));
            chk("hold_in_ready", 0, 32'(ir[0]), 32'h0);
        end
        chk("hold_valid", 0, 32'(ov[0]), 32'h1);
        ordy[0] = 1'b1; iv[0] = 1'b0;
        @(negedge clk);
        ordy[0] = 1'b0;
        chk("handoff_valid", 0, 32'(ov[0]), 32'h0);
    endtask

    task automatic exh(input int i);
        for (int k = 0; k < 512; k++) begin
            int t = 0;
            wait_ready(i);
            a[i] = 16'((k >> 5) & 15); b[i] = 16'((k >> 1) & 15); bin[i] = 1'(k & 1);
            iv[i] = 1'b1;
            @(negedge clk);
            iv[i] = 1'b0;
            while (!ov[i] && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("exh_latency", i, 32'(t), 32'(NDG[i]));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ordy[i] = 1'b1;
            @(negedge clk);
            ordy[i] = 1'b0;
        end
    endtask

    task automatic rand16(input int n);
        repeat (n) begin
            iv[0]  = 1'($urandom_range(0, 1));
            a[0]   = 16'($urandom);
            b[0]   = ($urandom_range(0, 3) == 0) ? a[0] : 16'($urandom);
            bin[0] = 1'($urandom);
            ordy[0] = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        repeat (8) @(negedge clk);
        ordy[0] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; bin[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        #22 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 0, 32'(ov[0]), 32'h0);
        chk("reset_ready", 0, 32'(ir[0]), 32'h1);
        chk("reset_diff", 0, 32'(dif[0]), 32'h0);

        op16(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 0);
        op16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
        op16(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 5);
        op16(16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);

        // Reset during the second RUN cycle.
        wait_ready(0);
        a[0] = 16'h5555; b[0] = 16'h1111; bin[0] = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 0, 32'(ov[0]), 32'h0);
        chk("midrst_ready", 0, 32'(ir[0]), 32'h1);
        chk("midrst_diff", 0, 32'(dif[0]), 32'h0);
        chk("midrst_flags", 0, {30'h0, bo[0], zr[0]}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        ordy[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_stale_valid", 0, 32'(ov[0]), 32'h0);
        end
        ordy[0] = 1'b0;

        base0 = ndone[0];
        fork
            exh(1);
            exh(2);
            rand16(400);
        join
        @(negedge clk);
        chk("exh_count", 1, 32'(ndone[1]), 32'd512);
        chk("exh_count", 2, 32'(ndone[2]), 32'd512);
        chk("rand_ops_seen", 0, 32'(ndone[0] - base0 > 10), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
